// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - data-memory/twiddle read and butterfly handshake bundle
interface fft_stage_sequencer_if #(
    parameter int FFT_N = 10
) ();
    logic             rd_en;
    logic [FFT_N-1:0] rd_addr_a;
    logic [FFT_N-1:0] rd_addr_b;
    logic [FFT_N-2:0] twiddle_addr;
    logic             bfly_iact;
    logic [1:0]       bfly_ictrl;
    logic [FFT_N-2:0] bfly_addr;
    logic             bfly_oact;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, twiddle_addr,
        output bfly_iact, bfly_ictrl, bfly_addr,
        input  bfly_oact
    );

    modport slave (
        input  rd_en, rd_addr_a, rd_addr_b, twiddle_addr,
        input  bfly_iact, bfly_ictrl, bfly_addr,
        output bfly_oact
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - in-place DIF FFT stage/butterfly address sequencer
// Optional FFT_SEQ_BITREV_EN adds a bit-reversed UNLOAD read pass after the last stage.
module fft_stage_sequencer #(
    parameter int FFT_N  = 10,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(FFT_N)-1:0]   stage,
    fft_stage_sequencer_if.master      bus
);
    localparam int N    = 1 << FFT_N;
    localparam int HALF = N / 2;
    localparam int SW   = $clog2(FFT_N);
    localparam logic [FFT_N-2:0] K_LAST     = (FFT_N-1)'(HALF - 1);
    localparam logic [SW-1:0]    STAGE_LAST = SW'(FFT_N - 1);

`ifdef FFT_SEQ_BITREV_EN
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, UNLOAD} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
`endif

    typedef struct packed {
        logic             act;
        logic [1:0]       ctrl;
        logic [FFT_N-2:0] idx;
    } dl_t;

    state_t           state;
    logic [FFT_N-2:0] k;
    logic             issue_act;
    logic [1:0]       issue_ctrl;
    logic [FFT_N-2:0] issue_k;
    logic [FFT_N-1:0] outstanding;
    dl_t              dl [RD_LAT];
    logic             dl_busy;

    logic [FFT_N-1:0] kx, span, mask, j_c, addr_a_c, addr_b_c;
    logic [FFT_N-2:0] tw_c;

    // Group base is k with the in-group bits cleared, doubled; the partner sits one span above.
    always_comb begin
        kx       = {1'b0, k};
        span     = FFT_N'(1) << ((FFT_N - 1) - int'(stage));
        mask     = span - FFT_N'(1);
        j_c      = kx & mask;
        addr_a_c = ((kx & ~mask) << 1) | j_c;
        addr_b_c = addr_a_c + span;
        tw_c     = (FFT_N-1)'(j_c << stage);
    end

    always_comb begin
        dl_busy = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            dl_busy = dl_busy | dl[i].act;
        end
    end

`ifdef FFT_SEQ_BITREV_EN
    logic [FFT_N-1:0] ucnt;

    function automatic logic [FFT_N-1:0] bitrev(input logic [FFT_N-1:0] v);
        for (int i = 0; i < FFT_N; i++) begin
            bitrev[i] = v[FFT_N-1-i];
        end
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            k                <= '0;
            stage            <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            bus.rd_en        <= 1'b0;
            bus.rd_addr_a    <= '0;
            bus.rd_addr_b    <= '0;
            bus.twiddle_addr <= '0;
            issue_act        <= 1'b0;
            issue_ctrl       <= '0;
            issue_k          <= '0;
`ifdef FFT_SEQ_BITREV_EN
            ucnt             <= '0;
`endif
        end else begin
            done      <= 1'b0;
            bus.rd_en <= 1'b0;
            issue_act <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        stage <= '0;
                        k     <= '0;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        bus.rd_en        <= 1'b1;
                        bus.rd_addr_a    <= addr_a_c;
                        bus.rd_addr_b    <= addr_b_c;
                        bus.twiddle_addr <= tw_c;
                        issue_act        <= 1'b1;
                        issue_ctrl       <= {k == K_LAST, k == '0};
                        issue_k          <= k;
                        if (k == K_LAST) begin
                            k     <= '0;
                            state <= DRAIN;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The read issued on the way in is still visible on rd_en and not yet counted.
                    if (!bus.rd_en && outstanding == '0 && !dl_busy) begin
                        if (stage != STAGE_LAST) begin
                            stage <= stage + 1'b1;
                            state <= ISSUE;
                        end else begin
`ifdef FFT_SEQ_BITREV_EN
                            ucnt  <= '0;
                            state <= UNLOAD;
`else
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
`ifdef FFT_SEQ_BITREV_EN
                UNLOAD: begin
                    if (!stall) begin
                        bus.rd_en        <= 1'b1;
                        bus.rd_addr_a    <= bitrev(ucnt);
                        bus.rd_addr_b    <= '0;
                        bus.twiddle_addr <= '0;
                        if (ucnt == FFT_N'(N - 1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            ucnt <= ucnt + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Butterfly tags ride RD_LAT cycles behind their read; the counter floors at 0 so
    // returns still in flight across a reset cannot wrap it.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= {issue_act, issue_ctrl, issue_k};
            for (int i = 1; i < RD_LAT; i++) begin
                dl[i] <= dl[i-1];
            end
            if (issue_act && !bus.bfly_oact) begin
                outstanding <= outstanding + 1'b1;
            end else if (!issue_act && bus.bfly_oact && outstanding != '0) begin
                outstanding <= outstanding - 1'b1;
            end
        end
    end

    assign bus.bfly_iact  = dl[RD_LAT-1].act;
    assign bus.bfly_ictrl = dl[RD_LAT-1].ctrl;
    assign bus.bfly_addr  = dl[RD_LAT-1].idx;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - scoreboard bench for fft_stage_sequencer (FFT_N=3, RD_LAT=2)
module tb_fft_stage_sequencer;
    localparam int FFT_N  = 3;
    localparam int RD_LAT = 2;
    localparam int N      = 8;
    localparam int RET    = RD_LAT + 6;

    logic       clk = 1'b0;
    logic       reset, start, stall;
    logic       busy, done;
    logic [1:0] stage;

    fft_stage_sequencer_if #(.FFT_N(FFT_N)) bus ();

    fft_stage_sequencer #(.FFT_N(FFT_N), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .stage (stage),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a; int b; int tw; int stg; int k; int ctrl; bit bfly;
    } rd_t;
    typedef struct {
        int k; int ctrl; int due;
    } bf_t;

    rd_t exp_rd[$];
    bf_t exp_bf[$];
    int  ret_q[$];
    int  cyc, total, bad;
    int  done_cnt, t_start, t_done, t_a;
    int  oact_cnt, hold_mode, hold_until;
    int  s1_rd_cnt, first_s1_oacts, first_s1_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference order: DIF groups then in-group offsets, which is k ascending.
    task automatic push_transform();
        rd_t e;
        for (int s = 0; s < FFT_N; s++) begin
            int span;
            span = N >> (s + 1);
            for (int g = 0; g < N / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    e.a    = g * 2 * span + j;
                    e.b    = e.a + span;
                    e.tw   = j << s;
                    e.stg  = s;
                    e.k    = g * span + j;
                    e.ctrl = (e.k == 0 ? 1 : 0) | (e.k == N / 2 - 1 ? 2 : 0);
                    e.bfly = 1'b1;
                    exp_rd.push_back(e);
                end
            end
        end
`ifdef FFT_SEQ_BITREV_EN
        begin
            int br[8];
            br = '{0, 4, 2, 6, 1, 5, 3, 7};
            for (int i = 0; i < N; i++) begin
                e = '{a: br[i], b: 0, tw: 0, stg: FFT_N - 1, k: 0, ctrl: 0, bfly: 1'b0};
                exp_rd.push_back(e);
            end
        end
`endif
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        start     = 1'b1;
        t_start   = cyc;
        s1_rd_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, (done_cnt != d0), 1);
        repeat (6) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
        check({tag, "_bf_left"}, exp_bf.size(), 0);
        check({tag, "_ret_left"}, ret_q.size(), 0);
        check({tag, "_outstanding"}, dut.outstanding, 0);
    endtask

    task automatic wait_s1_reads(input int want, input int budget);
        int n;
        n = 0;
        while (s1_rd_cnt < want && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("s1_reads_seen", (s1_rd_cnt >= want), 1);
    endtask

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Butterfly return model: each issue comes back RET cycles later, unless held.
    initial begin
        bus.bfly_oact = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.bfly_oact = 1'b0;
            if (ret_q.size() > 0 && ret_q[0] <= cyc && cyc >= hold_until) begin
                void'(ret_q.pop_front());
                bus.bfly_oact = 1'b1;
            end
        end
    end

    initial begin
        rd_t e;
        bf_t f;
        forever begin
            @(negedge clk);
            if (bus.bfly_oact) oact_cnt++;
            if (done) begin
                done_cnt++;
                t_done = cyc;
            end
            if (bus.rd_en) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected", bus.rd_en, 0);
                end else begin
                    e = exp_rd.pop_front();
                    check("rd_addr_a", bus.rd_addr_a, e.a);
                    if (e.bfly) begin
                        check("rd_addr_b", bus.rd_addr_b, e.b);
                        check("twiddle_addr", bus.twiddle_addr, e.tw);
                        check("rd_stage", stage, e.stg);
                        f = '{k: e.k, ctrl: e.ctrl, due: cyc + RD_LAT};
                        exp_bf.push_back(f);
                        ret_q.push_back(cyc + RET);
                        if (hold_mode != 0 && e.stg == 0 && e.k == N / 2 - 1) hold_until = cyc + 20;
                        if (e.stg == 1) begin
                            s1_rd_cnt++;
                            if (e.k == 0) begin
                                first_s1_oacts = oact_cnt;
                                first_s1_cyc   = cyc;
                            end
                        end
                    end
                end
            end
            if (bus.bfly_iact) begin
                if (exp_bf.size() == 0) begin
                    check("iact_unexpected", bus.bfly_iact, 0);
                end else begin
                    f = exp_bf.pop_front();
                    check("bfly_addr", bus.bfly_addr, f.k);
                    check("bfly_ictrl", bus.bfly_ictrl, f.ctrl);
                    check("bfly_latency", cyc, f.due);
                end
            end
        end
    end

    initial begin
        total = 0; bad = 0; done_cnt = 0; oact_cnt = 0;
        hold_mode = 0; hold_until = 0; s1_rd_cnt = 0;
        first_s1_oacts = -1; first_s1_cyc = 0; t_start = 0; t_done = 0;
        reset = 1'b1; start = 1'b0; stall = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_iact", bus.bfly_iact, 0);
        check("rst_stage", stage, 0);
        check("rst_addr_a", bus.rd_addr_a, 0);
        check("rst_outstanding", dut.outstanding, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Plain transform
        push_transform();
        do_start();
        check("a_busy", busy, 1);
        run_until_done("a", 500);
        t_a = t_done - t_start;

        // Five stall cycles in the middle of stage 1
        push_transform();
        do_start();
        wait_s1_reads(2, 300);
        stall = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("b_stall_rd_en", bus.rd_en, 0);
        end
        stall = 1'b0;
        run_until_done("b", 500);
        check("b_runtime", t_done - t_start, t_a + 5);

        // Stage-0 returns withheld for 20 cycles
        hold_mode = 1;
        oact_cnt  = 0;
        first_s1_oacts = -1;
        push_transform();
        do_start();
        run_until_done("c", 800);
        check("c_oacts_before_s1", first_s1_oacts, 4);
        check("c_s1_after_hold", (first_s1_cyc > hold_until), 1);
        hold_mode = 0;

        // Extra start while busy, then reset in stage 1
        push_transform();
        do_start();
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_s1_reads(2, 300);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_rd.delete();
        exp_bf.delete();
        reset = 1'b0;
        @(negedge clk);
        check("d_rst_busy", busy, 0);
        check("d_rst_stage", stage, 0);
        check("d_rst_rd_en", bus.rd_en, 0);
        check("d_rst_iact", bus.bfly_iact, 0);
        check("d_rst_outstanding", dut.outstanding, 0);
        repeat (RET + 6) @(negedge clk);
        check("d_stale_returned", ret_q.size(), 0);
        check("d_no_underflow", dut.outstanding, 0);
        check("d_idle_busy", busy, 0);
        push_transform();
        do_start();
        run_until_done("d2", 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
